bin2bcd_seq: RTL

Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm. It produces the packed 4-digit BCD word consumed by the 4-digit multiplexed seven-segment display driver: `bcd_out[15:12]` is thousands and `bcd_out[3:0]` is units. It uses one iterative datapath instead of a wide combinational divider. A result register holds the last conversion steady for the display between updates.

---
 rtl/bin2bcd_if.sv | 15 +
 rtl/bin2bcd_seq.sv | 117 +++++++++++
 2 files changed

// File: rtl/bin2bcd_if.sv
// Handshake and result bundle between a bin2bcd_seq converter and its client.
// The master drives requests. The slave (the converter) drives status and the packed BCD result.
interface bin2bcd_if #(
   parameter int BIN_W = 14
);
   logic             start;
   logic [BIN_W-1:0] bin;
   logic             busy;
   logic             done;
   logic [15:0]      bcd_out;
   logic             ovf;

   modport master (output start, bin, input busy, done, bcd_out, ovf);
   modport slave  (input start, bin, output busy, done, bcd_out, ovf);
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary to 4-digit packed BCD converter feeding the display driver.
// Optional saturation to 9999 with an ovf flag is enabled by defining BIN2BCD_SAT_EN.
module bin2bcd_seq #(
   parameter int BIN_W = 14
) (
   input logic       clk,
   input logic       rst,
   bin2bcd_if.slave  bus
);

   typedef enum logic {IDLE, SHIFT} state_t;

   localparam logic [4:0] LAST_STEP = 5'(BIN_W - 1);

   state_t           state, state_next;
   logic [BIN_W-1:0] bin_sr, bin_sr_next;
   logic [15:0]      scratch, scratch_next;
   logic [15:0]      corr;
   logic [15:0]      shifted;
   logic [4:0]       cnt, cnt_next;
   logic             done, done_next;
   logic [15:0]      bcd, bcd_next;
`ifdef BIN2BCD_SAT_EN
   localparam logic [BIN_W-1:0] MAX_DEC = BIN_W'(9999);
   logic             ovf, ovf_next;
   logic             pend, pend_next;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         bin_sr  <= '0;
         scratch <= '0;
         cnt     <= '0;
         done    <= 1'b0;
         bcd     <= '0;
`ifdef BIN2BCD_SAT_EN
         ovf     <= 1'b0;
         pend    <= 1'b0;
`endif
      end else begin
         state   <= state_next;
         bin_sr  <= bin_sr_next;
         scratch <= scratch_next;
         cnt     <= cnt_next;
         done    <= done_next;
         bcd     <= bcd_next;
`ifdef BIN2BCD_SAT_EN
         ovf     <= ovf_next;
         pend    <= pend_next;
`endif
      end
   end

   always_comb begin
      state_next   = state;
      bin_sr_next  = bin_sr;
      scratch_next = scratch;
      cnt_next     = cnt;
      done_next    = 1'b0;
      bcd_next     = bcd;
`ifdef BIN2BCD_SAT_EN
      ovf_next     = ovf;
      pend_next    = pend;
`endif

      // Add-3 correction on every nibble precedes the shift within the same step.
      corr = scratch;
      for (int i = 0; i < 4; i++) begin
         if (scratch[4*i +: 4] >= 4'd5) begin
            corr[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
         end
      end
      // The thousands nibble's carry-out is dropped, giving bin mod 10000.
      shifted = (corr << 1) | {15'b0, bin_sr[BIN_W-1]};

      case (state)
         IDLE: begin
            if (bus.start) begin
               state_next   = SHIFT;
               bin_sr_next  = bus.bin;
               scratch_next = '0;
               cnt_next     = '0;
`ifdef BIN2BCD_SAT_EN
               pend_next    = (bus.bin > MAX_DEC);
`endif
            end
         end
         SHIFT: begin
            scratch_next = shifted;
            bin_sr_next  = bin_sr << 1;
            cnt_next     = cnt + 5'd1;
            if (cnt == LAST_STEP) begin
               state_next = IDLE;
               done_next  = 1'b1;
`ifdef BIN2BCD_SAT_EN
               bcd_next   = pend ? 16'h9999 : shifted;
               ovf_next   = pend;
`else
               bcd_next   = shifted;
`endif
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.busy    = (state == SHIFT);
   assign bus.done    = done;
   assign bus.bcd_out = bcd;
`ifdef BIN2BCD_SAT_EN
   assign bus.ovf     = ovf;
`else
   assign bus.ovf     = 1'b0;
`endif

endmodule
